rf_writeback: RTL and testbench
===============================

RF_WRITEBACK -- requirements
Module: rf_writeback

Interface
REQ-001 SHALL expose parameter LDQ_DEPTH, default 2, load-result queue entries (power of two, >=2).
REQ-002 SHALL expose clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL expose rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL expose alu_valid/alu_rd/alu_data  input  1/5/32  single-cycle execute result; never stalled.
REQ-005 SHALL expose ld_valid/ld_rd/ld_data  input  1/5/32  load-unit result; transferred when ld_valid&&ld_ready.
REQ-006 SHALL expose ld_ready  output  1  queue not full.
REQ-007 SHALL expose issue_ld_valid/issue_ld_rd  input  1/5  decode issued a load targeting rd.
REQ-008 SHALL expose rs1_q/rs2_q  input  5/5  decode source registers for hazard query.
REQ-009 SHALL expose hazard  output  1  rs1_q or rs2_q has a pending load.
REQ-010 SHALL expose rf_we/rf_waddr/rf_wdata  output  1/5/32  registered register-file write port.

Function
REQ-011 SHALL select per cycle: alu_valid wins; else queue head if non-empty; else no write.
REQ-012 SHALL register the selection: rf_we/rf_waddr/rf_wdata update one cycle after the selecting edge's inputs.
REQ-013 SHALL drop any write with rd==0: rf_we=0, no queue pop suppression (entry still retired).
REQ-014 SHALL hold load results in an LDQ_DEPTH FIFO; push on ld_valid&&ld_ready, pop when selected.
REQ-015 SHALL allow push and pop in the same cycle when full only if pop occurs; ld_ready is combinational: !full || (!alu_valid && !empty).
REQ-016 SHALL wrap FIFO pointers modulo LDQ_DEPTH with an extra wrap bit distinguishing full from empty.
REQ-017 SHALL keep a 32-bit pending scoreboard: set bit issue_ld_rd on issue_ld_valid (rd!=0); clear bit on load pop.
REQ-018 SHALL give set priority over clear when both target the same register in one cycle.
REQ-019 SHALL never set bit 0; hazard = pending[rs1_q] || pending[rs2_q], combinational.
REQ-020 SHALL not alter the scoreboard on ALU writes.

Reset
REQ-021 SHALL on rst: rf_we=0, rf_waddr=0, rf_wdata=0, FIFO empty, ld_ready=1, scoreboard all-zero, hazard=0.
REQ-022 SHALL discard queued and in-flight results on rst mid-operation; no write follows reset release until new input.

Configuration
REQ-023 SHALL with WB_BYPASS_EN defined: add outputs fwd1_hit/fwd2_hit (1) and fwd_data (32); hit when rf_we && rf_waddr==rsN_q && rf_waddr!=0, and hazard excludes a register being cleared by the current pop.
REQ-024 SHALL without WB_BYPASS_EN: no fwd ports; hazard exactly per REQ-019.

Structure
REQ-025 SHALL place REG_ADDR_W=5, XLEN=32 and the write-port struct (we, waddr, wdata) in shared package rv32_pkg.
REQ-026 SHALL implement the load queue as sub-module wb_ldq (parameterised sync FIFO).

Verification
REQ-027 SHALL cover: alu_valid=1,rd=5,data=0x1234 -> next cycle rf_we=1,rf_waddr=5,rf_wdata=0x1234.
REQ-028 SHALL cover: load rd=7 data=0xDEAD with alu_valid=1 for 3 cycles -> load written on cycle 4, after the 3 ALU writes.
REQ-029 SHALL cover: alu_valid held high, 2 loads pushed -> ld_ready=0; third load waits; alu_valid drops -> pops in order.
REQ-030 SHALL cover: issue_ld_rd=9, rs1_q=9 -> hazard=1 until load to x9 pops; same-cycle issue+pop of x9 -> hazard stays 1.
REQ-031 SHALL cover: alu rd=0 data=0xFFFF_FFFF -> rf_we stays 0; issue_ld_rd=0 -> hazard never asserts.
REQ-032 SHALL cover: rst asserted with 2 queued loads and pending x3 -> rf_we=0, ld_ready=1, hazard=0 immediately.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32 widths and writeback/load-queue record types.
package rv32_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [XLEN-1:0]       wdata;
    } rf_wr_t;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } ld_entry_t;
endpackage

// File: rtl/wb_ldq.sv
// Synchronous FIFO holding load results until the writeback port is free.
module wb_ldq #(
    parameter int DEPTH = 2,
    parameter int W     = 37
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer tells full apart from empty.
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_data;
    end
endmodule

// File: rtl/rf_writeback.sv
// Register-file writeback arbiter: ALU results win, load results queue behind them.
// Optional WB_BYPASS_EN adds forwarding hit outputs and pop-aware hazard masking.
module rf_writeback
    import rv32_pkg::*;
#(
    parameter int LDQ_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  ld_valid,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [XLEN-1:0]       ld_data,
    output logic                  ld_ready,
    input  logic                  issue_ld_valid,
    input  logic [REG_ADDR_W-1:0] issue_ld_rd,
    input  logic [REG_ADDR_W-1:0] rs1_q,
    input  logic [REG_ADDR_W-1:0] rs2_q,
    output logic                  hazard,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [XLEN-1:0]       rf_wdata
`ifdef WB_BYPASS_EN
    ,
    output logic                  fwd1_hit,
    output logic                  fwd2_hit,
    output logic [XLEN-1:0]       fwd_data
`endif
);
    ld_entry_t           head, ld_in;
    logic                q_full, q_empty, q_pop, q_push;
    rf_wr_t              wr_nxt, wr_q;
    logic [NUM_REGS-1:0] pending, set_mask, clr_mask, pend_vis;

    assign ld_in    = '{rd: ld_rd, data: ld_data};
    assign q_pop    = !alu_valid && !q_empty;
    // A full queue still accepts a load in the cycle its head retires.
    assign ld_ready = !q_full || q_pop;
    assign q_push   = ld_valid && ld_ready;

    wb_ldq #(.DEPTH(LDQ_DEPTH), .W($bits(ld_entry_t))) u_ldq (
        .clk      (clk),
        .rst      (rst),
        .push     (q_push),
        .push_data(ld_in),
        .pop      (q_pop),
        .pop_data (head),
        .full     (q_full),
        .empty    (q_empty)
    );

    always_comb begin
        wr_nxt = '0;
        if (alu_valid) begin
            wr_nxt.we    = (alu_rd != '0);
            wr_nxt.waddr = alu_rd;
            wr_nxt.wdata = alu_data;
        end else if (q_pop) begin
            wr_nxt.we    = (head.rd != '0);
            wr_nxt.waddr = head.rd;
            wr_nxt.wdata = head.data;
        end
        if (!wr_nxt.we) wr_nxt = '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_q <= '0;
        else     wr_q <= wr_nxt;
    end

    assign rf_we    = wr_q.we;
    assign rf_waddr = wr_q.waddr;
    assign rf_wdata = wr_q.wdata;

    // x0 is never marked pending; a same-cycle issue re-arms a bit being cleared.
    assign set_mask = (issue_ld_valid && issue_ld_rd != '0) ? NUM_REGS'(1) << issue_ld_rd : '0;
    assign clr_mask = q_pop ? NUM_REGS'(1) << head.rd : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~clr_mask) | set_mask;
    end

`ifdef WB_BYPASS_EN
    assign pend_vis = pending & ~(clr_mask & ~set_mask);
    assign fwd1_hit = rf_we && (rf_waddr == rs1_q) && (rf_waddr != '0);
    assign fwd2_hit = rf_we && (rf_waddr == rs2_q) && (rf_waddr != '0);
    assign fwd_data = rf_wdata;
`else
    assign pend_vis = pending;
`endif

    assign hazard = pend_vis[rs1_q] || pend_vis[rs2_q];
endmodule

// File: tb/tb_rf_writeback.sv
// Table-driven bench for rf_writeback with a queue of expected register-file writes.
module tb_rf_writeback;
    logic        clk, rst;
    logic        alu_valid, ld_valid, ld_ready, issue_ld_valid, hazard, rf_we;
    logic [4:0]  alu_rd, ld_rd, issue_ld_rd, rs1_q, rs2_q, rf_waddr;
    logic [31:0] alu_data, ld_data, rf_wdata;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic av; logic [4:0] ard; logic [31:0] ad;
        logic lv; logic [4:0] lrd; logic [31:0] ld;
        logic iv; logic [4:0] ird;
        logic [4:0] r1, r2;
        logic e_rdy, e_hz, e_we; logic [4:0] e_addr; logic [31:0] e_data;
    } vec_t;

    typedef struct { logic we; logic [4:0] addr; logic [31:0] data; } wr_t;

    vec_t tbl[$];
    wr_t  exp_q[$];

    rf_writeback #(.LDQ_DEPTH(2)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .issue_ld_valid(issue_ld_valid), .issue_ld_rd(issue_ld_rd),
        .rs1_q(rs1_q), .rs2_q(rs2_q), .hazard(hazard),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [31:0] ad,
                                logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
                                logic rdy, logic hz, logic we, logic [4:0] addr, logic [31:0] data);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.iv = iv; v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.e_rdy = rdy; v.e_hz = hz; v.e_we = we; v.e_addr = addr; v.e_data = data;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        wr_t e;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
        ld_valid = v.lv; ld_rd = v.lrd; ld_data = v.ld;
        issue_ld_valid = v.iv; issue_ld_rd = v.ird;
        rs1_q = v.r1; rs2_q = v.r2;
        #1;
        check($sformatf("ld_ready[%0d]", idx), 32'(ld_ready), 32'(v.e_rdy));
        check($sformatf("hazard[%0d]", idx), 32'(hazard), 32'(v.e_hz));
        exp_q.push_back('{we: v.e_we, addr: v.e_addr, data: v.e_data});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("rf_we[%0d]", idx), 32'(rf_we), 32'(e.we));
        if (e.we) begin
            check($sformatf("rf_waddr[%0d]", idx), 32'(rf_waddr), 32'(e.addr));
            check($sformatf("rf_wdata[%0d]", idx), rf_wdata, e.data);
        end
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_data = 0;
        issue_ld_valid = 0; issue_ld_rd = 0; rs1_q = 0; rs2_q = 0;

        //   alu            load                issue  rs1 rs2  rdy hz  we addr data
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(1,5,'h1234,      0,0,0,        0,0,  0,0,  1,0, 1,5,'h1234));
        tbl.push_back(mk(1,1,'h11,        1,7,'hDEAD,   0,0,  0,0,  1,0, 1,1,'h11));
        tbl.push_back(mk(1,2,'h22,        0,0,0,        0,0,  0,0,  1,0, 1,2,'h22));
        tbl.push_back(mk(1,3,'h33,        0,0,0,        0,0,  0,0,  1,0, 1,3,'h33));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 1,7,'hDEAD));
        tbl.push_back(mk(1,4,'h44,        1,10,'hA0,    0,0,  0,0,  1,0, 1,4,'h44));
        tbl.push_back(mk(1,4,'h45,        1,11,'hA1,    0,0,  0,0,  1,0, 1,4,'h45));
        tbl.push_back(mk(1,4,'h46,        1,12,'hA2,    0,0,  0,0,  0,0, 1,4,'h46));
        tbl.push_back(mk(0,0,0,           1,12,'hA2,    0,0,  0,0,  1,0, 1,10,'hA0));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 1,11,'hA1));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 1,12,'hA2));
        tbl.push_back(mk(0,0,0,           0,0,0,        1,9,  9,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,1, 0,0,0));
        tbl.push_back(mk(1,6,'h66,        1,9,'h99,     0,0,  0,9,  1,1, 1,6,'h66));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,1, 1,9,'h99));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,0, 0,0,0));
        tbl.push_back(mk(1,6,'h67,        1,9,'h98,     1,9,  9,0,  1,0, 1,6,'h67));
        tbl.push_back(mk(0,0,0,           0,0,0,        1,9,  9,0,  1,1, 1,9,'h98));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,1, 0,0,0));
        tbl.push_back(mk(1,8,'h88,        1,9,'h97,     0,0,  9,0,  1,1, 1,8,'h88));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,1, 1,9,'h97));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  9,0,  1,0, 0,0,0));
        tbl.push_back(mk(1,0,'hFFFFFFFF,  0,0,0,        0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,        1,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           1,0,'h5,      0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           1,16,'h16,    0,0,  0,0,  1,0, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,0,  1,0, 1,16,'h16));
        tbl.push_back(mk(0,0,0,           0,0,0,        1,14, 0,14, 1,0, 0,0,0));
        tbl.push_back(mk(1,14,'hE,        0,0,0,        0,0,  0,14, 1,1, 1,14,'hE));
        tbl.push_back(mk(0,0,0,           0,0,0,        0,0,  0,14, 1,1, 0,0,0));
        tbl.push_back(mk(1,1,'h1,         1,20,'h20,    1,3,  3,0,  1,0, 1,1,'h1));
        tbl.push_back(mk(1,2,'h2,         1,21,'h21,    0,0,  3,0,  1,1, 1,2,'h2));

        #2;
        check("reset rf_we", 32'(rf_we), 0);
        check("reset rf_waddr", 32'(rf_waddr), 0);
        check("reset rf_wdata", rf_wdata, 0);
        check("reset ld_ready", 32'(ld_ready), 1);
        check("reset hazard", 32'(hazard), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) apply(i, tbl[i]);

        // Queue full behind a held ALU stream, x3 and x14 pending: then reset mid-flight.
        alu_valid = 1; alu_rd = 4; alu_data = 'h4;
        ld_valid = 0; issue_ld_valid = 0; rs1_q = 3; rs2_q = 14;
        #1;
        check("full ld_ready", 32'(ld_ready), 0);
        check("pre-rst hazard", 32'(hazard), 1);
        rst = 1'b1;
        #1;
        check("mid-rst rf_we", 32'(rf_we), 0);
        check("mid-rst rf_waddr", 32'(rf_waddr), 0);
        check("mid-rst rf_wdata", rf_wdata, 0);
        check("mid-rst ld_ready", 32'(ld_ready), 1);
        check("mid-rst hazard", 32'(hazard), 0);
        @(negedge clk);
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++)
            apply(100 + i, mk(0,0,0, 0,0,0, 0,0, 3,14, 1,0, 0,0,0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
